// File: rtl/isp_pkg.sv
// isp_pkg: shared pixel type, VGA 640x480@60 timing constants and the
// frame-buffer geometry used by vga_timing_gen and frame_buffer_reader.
// Ports: none (package). Also holds the test-pattern bar colour lookup.
package isp_pkg;

    typedef logic [11:0] rgb444_t;

    localparam int H_ACT_PX  = 640;
    localparam int H_FP_PX   = 16;
    localparam int H_SYNC_PX = 96;
    localparam int H_BP_PX   = 48;

    localparam int V_ACT_LN  = 480;
    localparam int V_FP_LN   = 10;
    localparam int V_SYNC_LN = 2;
    localparam int V_BP_LN   = 33;

    localparam int FB_W_PX   = 320;

    // Counter state captured on one pixel tick, presented on the next.
    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic [9:0] x;
        logic [8:0] y;
    } pix_t;

    // Eight 80-column bars across the active line.
    function automatic rgb444_t bar_color(input logic [9:0] x);
        rgb444_t c;
        if (x < 10'd80)       c = 12'hFFF;
        else if (x < 10'd160) c = 12'hFF0;
        else if (x < 10'd240) c = 12'h0FF;
        else if (x < 10'd320) c = 12'h0F0;
        else if (x < 10'd400) c = 12'hF0F;
        else if (x < 10'd480) c = 12'hF00;
        else if (x < 10'd560) c = 12'h00F;
        else                  c = 12'h000;
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v pixel counters advanced on the pixel tick, with
// combinational sync (active-low) and active-region decode of the count.
// Ports: clk_i, reset_i (sync, high), pclk_en_i in; h_cnt_o, v_cnt_o,
//        active_o, h_sync_o, v_sync_o out.
module vga_timing_gen
    import isp_pkg::*;
#(
    parameter int H_ACTIVE = H_ACT_PX,
    parameter int V_ACTIVE = V_ACT_LN
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pclk_en_i,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       active_o,
    output logic       h_sync_o,
    output logic       v_sync_o
);

    localparam int H_TOT = H_ACTIVE + H_FP_PX + H_SYNC_PX + H_BP_PX;
    localparam int V_TOT = V_ACTIVE + V_FP_LN + V_SYNC_LN + V_BP_LN;

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP_PX);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP_PX + H_SYNC_PX - 1);

    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP_LN);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP_LN + V_SYNC_LN - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pclk_en_i) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o  = h_cnt_q;
    assign v_cnt_o  = v_cnt_q;
    assign active_o = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign h_sync_o = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    assign v_sync_o = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));

endmodule

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: scans a 2x-upscaled frame buffer into a VGA pixel
// stream with one pixel tick of latency; all outputs registered.
// Ports: clk, reset (sync, high), pclk_en, rd_data in; rd_en, rd_addr,
//        x_coor, y_coor, oe, h_sync, v_sync, frame_start, RGB444_data out.
// Macro TEST_PATTERN_EN adds input pattern_en selecting 8 colour bars.
module frame_buffer_reader
    import isp_pkg::*;
#(
    parameter int H_ACTIVE = H_ACT_PX,
    parameter int V_ACTIVE = V_ACT_LN,
    parameter int FB_WIDTH = FB_W_PX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pclk_en,
    output logic        rd_en,
    output logic [16:0] rd_addr,
    input  rgb444_t     rd_data,
    output logic [9:0]  x_coor,
    output logic [8:0]  y_coor,
    output logic        oe,
    output logic        h_sync,
    output logic        v_sync,
    output logic        frame_start,
    output rgb444_t     RGB444_data
`ifdef TEST_PATTERN_EN
    ,
    input  logic        pattern_en
`endif
);

    localparam pix_t PIX_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1,
                                  x: '0, y: '0};

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       hs;
    logic       vs;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_timing (
        .clk_i     (clk),
        .reset_i   (reset),
        .pclk_en_i (pclk_en),
        .h_cnt_o   (h_cnt),
        .v_cnt_o   (v_cnt),
        .active_o  (active),
        .h_sync_o  (hs),
        .v_sync_o  (vs)
    );

    // Frame-buffer address: (v/2)*FB_WIDTH + h/2.
    logic [8:0]  fb_row;
    logic [16:0] row_base;
    logic [16:0] addr_d;

    assign fb_row = v_cnt[9:1];

    generate
        if (FB_WIDTH == 320) begin : g_shift
            // 320 = 256 + 64, so two shifts and an add replace the multiply.
            assign row_base = ({8'd0, fb_row} << 8) + ({8'd0, fb_row} << 6);
        end else begin : g_mul
            assign row_base = {8'd0, fb_row} * 17'(FB_WIDTH);
        end
    endgenerate

    assign addr_d = row_base + {8'd0, h_cnt[9:1]};

    logic        rd_en_q;
    logic        rd_vld_q;
    logic [16:0] rd_addr_q;
    rgb444_t     data_q;
    pix_t        s1_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic        oe_q;
    logic        hs_q;
    logic        vs_q;
    logic        fs_q;
    rgb444_t     rgb_q;

    logic        rd_req;
    rgb444_t     fb_pix;
    rgb444_t     pix_src;

    // Ticks may be only 2 clk apart, so the presenting tick can coincide
    // with the data-valid cycle: bypass the capture register then.
    assign fb_pix = rd_vld_q ? rd_data : data_q;

`ifdef TEST_PATTERN_EN
    logic    pat_q;
    rgb444_t bar_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q <= 1'b0;
            bar_q <= '0;
        end else if (pclk_en) begin
            pat_q <= pattern_en;
            bar_q <= bar_color(h_cnt);
        end
    end

    assign rd_req  = active && !pattern_en;
    assign pix_src = pat_q ? bar_q : fb_pix;
`else
    assign rd_req  = active;
    assign pix_src = fb_pix;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            data_q    <= '0;
            s1_q      <= PIX_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            oe_q      <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            fs_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            rd_en_q  <= pclk_en && rd_req;
            rd_vld_q <= rd_en_q;
            fs_q     <= 1'b0;
            if (rd_vld_q) begin
                data_q <= rd_data;
            end
            if (pclk_en) begin
                if (rd_req) begin
                    rd_addr_q <= addr_d;
                end
                s1_q <= '{act: active, hs: hs, vs: vs,
                          x: h_cnt, y: v_cnt[8:0]};
                oe_q  <= s1_q.act;
                x_q   <= s1_q.act ? s1_q.x : '0;
                y_q   <= s1_q.act ? s1_q.y : '0;
                hs_q  <= s1_q.hs;
                vs_q  <= s1_q.vs;
                rgb_q <= s1_q.act ? pix_src : '0;
                fs_q  <= s1_q.act && (s1_q.x == '0) && (s1_q.y == '0);
            end
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign x_coor      = x_q;
    assign y_coor      = y_q;
    assign oe          = oe_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign frame_start = fs_q;
    assign RGB444_data = rgb_q;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader: random pixel-tick spacing and resets against a
// tick-indexed model of the raster; reduced active size keeps runs short.
// Honours TEST_PATTERN_EN (drives pattern_en when the macro is defined).
module tb_frame_buffer_reader;

    localparam int HA    = 96;
    localparam int VA    = 4;
    localparam int FBW   = 320;
    localparam int HT    = HA + 16 + 96 + 48;
    localparam int VT    = VA + 10 + 2 + 33;
    localparam int FRAME = HT * VT;

    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic        clk = 1'b0;
    logic        reset;
    logic        pclk_en;
    logic        pattern_en;
    logic        rd_en;
    logic [16:0] rd_addr;
    logic [11:0] rd_data;
    logic [9:0]  x_coor;
    logic [8:0]  y_coor;
    logic        oe;
    logic        h_sync;
    logic        v_sync;
    logic        frame_start;
    logic [11:0] RGB444_data;

    always #5 clk = ~clk;

    frame_buffer_reader #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA),
        .FB_WIDTH (FBW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pclk_en     (pclk_en),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .x_coor      (x_coor),
        .y_coor      (y_coor),
        .oe          (oe),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .frame_start (frame_start),
        .RGB444_data (RGB444_data)
`ifdef TEST_PATTERN_EN
        ,
        .pattern_en  (pattern_en)
`endif
    );

    // RAM returns its address; garbage whenever no read is in flight.
    always @(posedge clk)
        rd_data <= rd_en ? rd_addr[11:0] : 12'($urandom);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // ---------------- model: state k = tick index since reset ----------
    int n = 0;
    bit ppat = 0;
    bit tk = 0;
    bit r_seen = 1;
    bit chk_last = 0;
    int pres_h = -1, pres_v = -1;
    bit pres_pat = 0;
    int e_rd_en = 0, e_addr = 0, e_x = 0, e_y = 0, e_oe = 0;
    int e_hs = 1, e_vs = 1, e_fs = 0, e_rgb = 0;

    function automatic bit pat_now();
`ifdef TEST_PATTERN_EN
        return pattern_en;
`else
        return 1'b0;
`endif
    endfunction

    task automatic present_idle();
        e_oe = 0; e_x = 0; e_y = 0; e_hs = 1; e_vs = 1; e_rgb = 0;
        pres_h = -1; pres_v = -1; pres_pat = 0;
    endtask

    task automatic present(input int k, input bit pat);
        int h, v;
        bit act;
        h = k % HT;
        v = (k / HT) % VT;
        act = (h < HA) && (v < VA);
        e_oe = act;
        e_x = act ? h : 0;
        e_y = act ? v : 0;
        e_hs = !(h >= HA + 16 && h < HA + 16 + 96);
        e_vs = !(v >= VA + 10 && v < VA + 12);
        if (!act) e_rgb = 0;
        else if (pat) e_rgb = BARS[h / 80];
        else e_rgb = ((v / 2) * FBW + h / 2) % 4096;
        e_fs = act && h == 0 && v == 0;
        pres_h = h; pres_v = v; pres_pat = pat;
    endtask

    always @(posedge clk) begin
        int h, v;
        tk = 0;
        chk_last = 0;
        r_seen = reset;
        if (reset) begin
            n = 0; ppat = 0;
            present_idle();
            e_rd_en = 0; e_addr = 0; e_fs = 0;
        end else begin
            e_rd_en = 0; e_fs = 0;
            if (pclk_en) begin
                tk = 1;
                if (n == 0) present_idle();
                else present(n - 1, ppat);
                h = n % HT;
                v = (n / HT) % VT;
                if (h < HA && v < VA && !pat_now()) begin
                    e_rd_en = 1;
                    e_addr = (v / 2) * FBW + h / 2;
                    chk_last = (h == HA - 1) && (v == VA - 1);
                end
                ppat = pat_now();
                n++;
            end
        end
    end

    // ---------------- compare ----------------
    bit seen_fs = 0;
    int f_ticks = 0, f_hs = 0, f_vs = 0, f_done = 0;

    always @(negedge clk) begin
        chk("rd_en", 32'(rd_en), 32'(e_rd_en));
        chk("rd_addr", 32'(rd_addr), 32'(e_addr));
        chk("x_coor", 32'(x_coor), 32'(e_x));
        chk("y_coor", 32'(y_coor), 32'(e_y));
        chk("oe", 32'(oe), 32'(e_oe));
        chk("h_sync", 32'(h_sync), 32'(e_hs));
        chk("v_sync", 32'(v_sync), 32'(e_vs));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("rgb", 32'(RGB444_data), 32'(e_rgb));

        if (r_seen) begin
            chk("rst_rd", 32'({rd_en, rd_addr}), 32'd0);
            chk("rst_pos", 32'({oe, y_coor, x_coor}), 32'd0);
            chk("rst_sync", 32'({h_sync, v_sync, frame_start}), 32'b110);
            chk("rst_rgb", 32'(RGB444_data), 32'd0);
            seen_fs = 0;
        end
        if (tk && pres_h == 5 && pres_v == 3 && !pres_pat)
            chk("rgb_x5_y3", 32'(RGB444_data), 32'h142);
        if (tk && pres_h == HA - 1 && pres_v == VA - 1 && !pres_pat)
            chk("rgb_last", 32'(RGB444_data), 32'h16F);
        if (chk_last)
            chk("rd_addr_last", 32'(rd_addr), 32'd367);
        if (tk && pres_h == HA && pres_v == 0) begin
            chk("edge_oe", 32'(oe), 32'd0);
            chk("edge_rgb", 32'(RGB444_data), 32'd0);
            chk("edge_rd_en", 32'(rd_en), 32'd0);
        end
        if (frame_start)
            chk("fs_pos", 32'({oe, y_coor, x_coor}), 32'h80000);
`ifdef TEST_PATTERN_EN
        if (tk && pres_pat && pres_v >= 0 && pres_v < VA) begin
            if (pres_h >= 0 && pres_h < 80)
                chk("bar0", 32'(RGB444_data), 32'hFFF);
            if (pres_h == 80 || pres_h == HA - 1)
                chk("bar1", 32'(RGB444_data), 32'hFF0);
        end
        if (tk && ppat)
            chk("pat_no_rd", 32'(rd_en), 32'd0);
`endif
        if (tk && !r_seen) begin
            if (frame_start) begin
                if (seen_fs) begin
                    chk("frame_ticks", 32'(f_ticks), 32'(FRAME));
                    chk("frame_hs_low", 32'(f_hs), 32'(96 * VT));
                    chk("frame_vs_low", 32'(f_vs), 32'(2 * HT));
                    f_done++;
                end
                seen_fs = 1;
                f_ticks = 0; f_hs = 0; f_vs = 0;
            end
            f_ticks++;
            f_hs += !h_sync;
            f_vs += !v_sync;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            pclk_en = 1'b1;
`ifdef TEST_PATTERN_EN
            if ($urandom_range(0, 399) == 0) pattern_en = !pattern_en;
`endif
            @(negedge clk);
            pclk_en = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        pclk_en = 1'b0;
        pattern_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        run(200);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run(40);
        // Reset lands while a read is in flight.
        pclk_en = 1'b1;
        @(negedge clk);
        pclk_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`ifdef TEST_PATTERN_EN
        pattern_en = 1'b1;
        run(HT * 2);
        pattern_en = 1'b0;
        run(FRAME + 300 - HT * 2);
`else
        run(FRAME + 300);
`endif
        @(negedge clk);
        chk("frames_checked", 32'(f_done), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
